sipo_word_collector: RTL

Downstream consumer of the 4-bit PISO load-enable shift register. It samples the serial bit stream (the PISO shiftOut, qualified by the same shift enable) and reassembles it into parallel words. Completed words sit in a one-deep output holding register and leave through a valid/ready handshake. Words that arrive while that register is full are dropped, and an overrun is flagged.

---
 rtl/sipo_word_collector.sv | 90 +++++++++
 1 files changed

// File: rtl/sipo_word_collector.sv
// Serial-in, parallel-out word collector. It gathers WIDTH sampled bits into a word
// and hands the word off through a one-deep valid/ready holding register that reports overruns.
module sipo_word_collector #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     serialIn,
   input  logic                     bitValid,
   input  logic                     clear,
   output logic [WIDTH-1:0]         wordOut,
   output logic                     wordValid,
   input  logic                     wordReady,
   output logic [$clog2(WIDTH):0]   bitCount,
   output logic                     overrun
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      shift_d   = shift_q;
      count_d   = count_q;
      word_d    = word_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      if (MSB_FIRST) begin
         shifted = {shift_q[WIDTH-2:0], serialIn};
      end else begin
         shifted = {serialIn, shift_q[WIDTH-1:1]};
      end

      if (valid_q && wordReady) begin
         valid_d = 1'b0;
      end

      // clear wins over a sampled bit, so a clear on the last bit suppresses completion
      if (clear) begin
         shift_d   = '0;
         count_d   = '0;
         overrun_d = 1'b0;
      end else if (bitValid) begin
         if (count_q == LAST_BIT) begin
            shift_d = '0;
            count_d = '0;
            if (!valid_q || wordReady) begin
               word_d  = shifted;
               valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end else begin
            shift_d = shifted;
            count_d = count_q + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         shift_q   <= '0;
         count_q   <= '0;
         word_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         count_q   <= count_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign wordOut   = word_q;
   assign wordValid = valid_q;
   assign bitCount  = count_q;
   assign overrun   = overrun_q;

endmodule
